nbit_1to2_demux_reg: RTL

//   Registered N-bit 1-to-2 stream demultiplexer: the splitting counterpart of the
//   N-bit 2-to-1 mux. Routes each accepted input word to output A (in_sel=1) or

---
 rtl/nbit_1to2_demux_reg_if.sv | 38 +++
 rtl/nbit_1to2_demux_reg.sv | 91 +++++++++
 2 files changed

// File: rtl/nbit_1to2_demux_reg_if.sv
// Stream bundle for the registered 1-to-2 demux: one producer side, two
// consumer ports, plus delivered-word counters and a busy flag.
interface nbit_1to2_demux_reg_if #(
  parameter int N  = 1,
  parameter int CW = 8
);
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_data;
  logic          a_valid;
  logic          a_ready;
  logic [N-1:0]  b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          busy;

  modport master (
    output in_data, in_sel, in_valid,
    output a_ready, b_ready,
    input  in_ready,
    input  a_data, a_valid,
    input  b_data, b_valid,
    input  cnt_a, cnt_b, busy
  );

  modport slave (
    input  in_data, in_sel, in_valid,
    input  a_ready, b_ready,
    output in_ready,
    output a_data, a_valid,
    output b_data, b_valid,
    output cnt_a, cnt_b, busy
  );
endinterface

// File: rtl/nbit_1to2_demux_reg.sv
// Registered N-bit 1-to-2 stream demux: in_sel=1 routes to A, 0 to B,
// one-word output slot per port, per-port delivered-word counters.
module nbit_1to2_demux_reg #(
  parameter int N  = 1,
  parameter int CW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  nbit_1to2_demux_reg_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e         r_a_st;
  slot_e         r_b_st;
  logic [N-1:0]  r_a_data;
  logic [N-1:0]  r_b_data;
  logic [CW-1:0] r_cnt_a;
  logic [CW-1:0] r_cnt_b;

  logic w_a_full;
  logic w_b_full;
  logic w_a_free;
  logic w_b_free;
  logic w_in_ready;
  logic w_accept;
  logic w_load_a;
  logic w_load_b;
  logic w_drain_a;
  logic w_drain_b;

  assign w_a_full  = (r_a_st == FULL);
  assign w_b_full  = (r_b_st == FULL);
  assign w_drain_a = w_a_full & bus.a_ready;
  assign w_drain_b = w_b_full & bus.b_ready;

  // A slot can take a word if it is empty or is being drained this cycle.
  assign w_a_free = !w_a_full | bus.a_ready;
  assign w_b_free = !w_b_full | bus.b_ready;

  assign w_in_ready = !rst &
    (bus.in_sel ? w_a_free : w_b_free);
  assign w_accept = bus.in_valid & w_in_ready;
  assign w_load_a = w_accept & bus.in_sel;
  assign w_load_b = w_accept & !bus.in_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_st   <= EMPTY;
      r_a_data <= '0;
      r_cnt_a  <= '0;
    end else begin
      if (w_load_a) begin
        r_a_st   <= FULL;
        r_a_data <= bus.in_data;
      end else if (w_drain_a) begin
        r_a_st   <= EMPTY;
      end
      if (w_drain_a) r_cnt_a <= r_cnt_a + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_st   <= EMPTY;
      r_b_data <= '0;
      r_cnt_b  <= '0;
    end else begin
      if (w_load_b) begin
        r_b_st   <= FULL;
        r_b_data <= bus.in_data;
      end else if (w_drain_b) begin
        r_b_st   <= EMPTY;
      end
      if (w_drain_b) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.a_data   = r_a_data;
  assign bus.a_valid  = w_a_full;
  assign bus.b_data   = r_b_data;
  assign bus.b_valid  = w_b_full;
  assign bus.cnt_a    = r_cnt_a;
  assign bus.cnt_b    = r_cnt_b;
  assign bus.busy     = w_a_full | w_b_full;

endmodule
